alu_16: RTL and testbench



---
 rtl/alu_16_pkg.sv | 17 +
 rtl/alu_16_if.sv | 27 ++
 rtl/alu_16_core.sv | 44 ++++
 rtl/alu_16.sv | 61 ++++++
 tb/tb_alu_16.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_16_pkg.sv
// Shared ALU definitions: operand width and opcode encodings used by RTL and benches.
package alu_16_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_16_if.sv
// Operand/result/flag bundle between the execute-stage driver and the ALU.
interface alu_16_if;
    import alu_16_pkg::*;

    logic               flag_we;
    alu_op_e            alu_op;
    logic [ALU_W-1:0]   alu_a;
    logic [ALU_W-1:0]   alu_b;
    logic [ALU_W-1:0]   alu_out;
    logic               z;
    logic               v;
    logic               n;
    logic               z_q;
    logic               v_q;
    logic               n_q;

    modport master (
        output flag_we, alu_op, alu_a, alu_b,
        input  alu_out, z, v, n, z_q, v_q, n_q
    );

    modport slave (
        input  flag_we, alu_op, alu_a, alu_b,
        output alu_out, z, v, n, z_q, v_q, n_q
    );

endinterface

// File: rtl/alu_16_core.sv
// Combinational ALU core: result plus zero/overflow/sign flags in one evaluation.
module alu_16_core
    import alu_16_pkg::*;
(
    input  alu_op_e          op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] res,
    output logic             z,
    output logic             v,
    output logic             n
);

    logic [3:0] shamt;
    assign shamt = b[3:0];

    // Result and flags; only ADD/SUB produce sign and overflow.
    always_comb begin
        res = '0;
        v   = 1'b0;
        n   = 1'b0;
        case (op)
            ALU_ADD: begin
                res = a + b;
                v   = (a[15] == b[15]) && (res[15] != a[15]);
                n   = res[15];
            end
            ALU_SUB: begin
                res = a - b;
                v   = (a[15] != b[15]) && (res[15] != a[15]);
                n   = res[15];
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NAND: res = ~(a & b);
            ALU_SHL:  res = a << shamt;
            ALU_SHR:  res = a >> shamt;
            default:  res = '0;
        endcase
        z = (res == '0);
    end

endmodule

// File: rtl/alu_16.sv
// 16-bit ALU top: combinational core plus a write-enabled condition-code register.
module alu_16
    import alu_16_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu_16_if.slave   bus
);

    logic [ALU_W-1:0] core_out;
    logic             core_z;
    logic             core_v;
    logic             core_n;

    logic z_d, v_d, n_d;
    logic z_q, v_q, n_q;

    alu_16_core u_core (
        .op  (bus.alu_op),
        .a   (bus.alu_a),
        .b   (bus.alu_b),
        .res (core_out),
        .z   (core_z),
        .v   (core_v),
        .n   (core_n)
    );

    // Load fresh flags when requested, otherwise hold the previous condition codes.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (bus.flag_we) begin
            z_d = core_z;
            v_d = core_v;
            n_d = core_n;
        end
    end

    // Flag register; reset clears it immediately and overrides a simultaneous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    assign bus.alu_out = core_out;
    assign bus.z       = core_z;
    assign bus.v       = core_v;
    assign bus.n       = core_n;
    assign bus.z_q     = z_q;
    assign bus.v_q     = v_q;
    assign bus.n_q     = n_q;

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed cases, randomized ops against a model, flag-register sequence.
module tb_alu_16;
    import alu_16_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_16_if bus ();

    alu_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definitions (signed integer range for overflow).
    function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic z, output logic v,
                                    output logic n);
        int sa, sb, s, ua, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        p  = 1 << int'(b[3:0]);
        r  = 16'h0;
        v  = 1'b0;
        n  = 1'b0;
        case (op)
            3'd0: begin
                s = sa + sb;
                r = s[15:0];
                v = (s > 32767) || (s < -32768);
                n = r[15];
            end
            3'd1: begin
                s = sa - sb;
                r = s[15:0];
                v = (s > 32767) || (s < -32768);
                n = r[15];
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a & b);
            3'd6: begin
                s = (ua * p) % 65536;
                r = s[15:0];
            end
            default: begin
                s = ua / p;
                r = s[15:0];
            end
        endcase
        z = (r == 16'h0);
    endfunction

    task automatic apply_and_check(input string tag, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic ez, ev, en;
        bus.alu_op = alu_op_e'(op);
        bus.alu_a  = a;
        bus.alu_b  = b;
        #1;
        ref_alu(op, a, b, r, ez, ev, en);
        $display("[TB] %s op=%0d a=%04h b=%04h out=%04h z=%0b v=%0b n=%0b", tag, op, a, b,
                 bus.alu_out, bus.z, bus.v, bus.n);
        check({tag, ".out"}, 32'(bus.alu_out), 32'(r));
        check({tag, ".z"}, 32'(bus.z), 32'(ez));
        check({tag, ".v"}, 32'(bus.v), 32'(ev));
        check({tag, ".n"}, 32'(bus.n), 32'(en));
    endtask

    task automatic check_flags(input string tag, input logic ez, input logic ev, input logic en);
        $display("[TB] %s z_q=%0b v_q=%0b n_q=%0b", tag, bus.z_q, bus.v_q, bus.n_q);
        check({tag, ".z_q"}, 32'(bus.z_q), 32'(ez));
        check({tag, ".v_q"}, 32'(bus.v_q), 32'(ev));
        check({tag, ".n_q"}, 32'(bus.n_q), 32'(en));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        z;
        logic        v;
        logic        n;
    } dir_vec_t;

    dir_vec_t dir_tab [7];

    initial begin
        logic [15:0] r;
        logic ez, ev, en;
        logic mz, mv, mn;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic we;

        n_tests = 0;
        n_fail  = 0;

        // Directed vectors with hand-written expected values.
        dir_tab[0] = '{3'd5, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        dir_tab[1] = '{3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        dir_tab[2] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
        dir_tab[3] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        dir_tab[4] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        dir_tab[5] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1};
        dir_tab[6] = '{3'd6, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0};

        rst         = 1'b1;
        bus.flag_we = 1'b0;
        bus.alu_op  = ALU_ADD;
        bus.alu_a   = 16'h0;
        bus.alu_b   = 16'h0;
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bus.alu_op = alu_op_e'(dir_tab[i].op);
            bus.alu_a  = dir_tab[i].a;
            bus.alu_b  = dir_tab[i].b;
            #1;
            $display("[TB] dir%0d op=%0d a=%04h b=%04h out=%04h z=%0b v=%0b n=%0b", i,
                     dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, bus.alu_out, bus.z, bus.v, bus.n);
            check($sformatf("dir%0d.out", i), 32'(bus.alu_out), 32'(dir_tab[i].out));
            check($sformatf("dir%0d.z", i), 32'(bus.z), 32'(dir_tab[i].z));
            check($sformatf("dir%0d.v", i), 32'(bus.v), 32'(dir_tab[i].v));
            check($sformatf("dir%0d.n", i), 32'(bus.n), 32'(dir_tab[i].n));
        end

        // Randomized operations with random flag writes, tracked against a flag model.
        mz = 1'b0;
        mv = 1'b0;
        mn = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 16'h7FFF;
                2: a = 16'h8000;
                default: ;
            endcase
            we = 1'($urandom_range(0, 1));
            bus.flag_we = we;
            apply_and_check($sformatf("rnd%0d", i), op, a, b);
            ref_alu(op, a, b, r, ez, ev, en);
            @(posedge clk);
            if (we) begin
                mz = ez;
                mv = ev;
                mn = en;
            end
            #1;
            check_flags($sformatf("rnd%0d.reg", i), mz, mv, mn);
        end

        // Flag register sequence: reset pulse, capture, hold, asynchronous clear.
        @(negedge clk);
        bus.flag_we = 1'b0;
        rst = 1'b1;
        #1;
        check_flags("seq.rst_pulse", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.flag_we = 1'b1;
        apply_and_check("seq.sub55", 3'd1, 16'h0005, 16'h0005);
        @(posedge clk);
        #1;
        check_flags("seq.capture", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.flag_we = 1'b0;
        apply_and_check("seq.add12", 3'd0, 16'h0001, 16'h0002);
        @(posedge clk);
        #1;
        check_flags("seq.hold", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_flags("seq.async_clr", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset held across a write edge must win.
        @(negedge clk);
        bus.flag_we = 1'b1;
        apply_and_check("seq.sub55b", 3'd1, 16'h0005, 16'h0005);
        @(posedge clk);
        #1;
        check_flags("seq.capture2", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        apply_and_check("seq.ovf", 3'd0, 16'h7FFF, 16'h0001);
        @(posedge clk);
        #1;
        check_flags("seq.rst_wins", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.flag_we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
